// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared widths and loader state encoding
package prog_loader_pkg;
  localparam int ADDR_LEN = 32;
  localparam int INSN_LEN = 32;
  localparam int HDR_LEN = 32;
  typedef enum logic [2:0] {HDR_I, IMEM, HDR_D, DMEM, CSUM, DONE, ERR} state_t;
endpackage

// File: rtl/prog_byte_asm.sv
// prog_byte_asm: byte-wide shift register assembling lines/words, with a byte counter
module prog_byte_asm
  import prog_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    shift,
  input  logic [7:0]              din,
  output logic [4*INSN_LEN-1:0]   data,
  output logic                    line_done,
  output logic                    word_done
);
  logic [3:0] cnt;
  always_ff @(posedge clk)
    if (reset) begin
      data <= '0;
      cnt  <= '0;
    end else begin
      if (shift) data <= {din, data[4*INSN_LEN-1:8]};
      cnt <= clr ? 4'd0 : shift ? cnt + 4'd1 : cnt;
    end
  assign line_done = shift && cnt == 4'hf;
  assign word_done = shift && cnt[1:0] == 2'd3;
endmodule

// File: rtl/prog_loader.sv
// prog_loader: boot loader streaming bytes into imem/dmem; PROG_LOADER_CHECKSUM_EN adds a trailing XOR byte
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IMEM_LINES = 512,
  parameter int DMEM_WORDS = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  prog_loading,
  output logic [4*INSN_LEN-1:0] prog_loaddata,
  output logic [ADDR_LEN-1:0]   prog_loadaddr,
  output logic                  prog_imem_we,
  output logic                  prog_dmem_we,
  output logic                  loaded,
  output logic                  load_err
);
  localparam int WW = $clog2(DMEM_WORDS) + 1;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t FIN = CSUM;
  logic [7:0] csum;
`else
  localparam state_t FIN = DONE;
`endif
  state_t state, nxt;
  logic wr, hs, line_done, word_done, last_line, last_word;
  logic [9:0] line_idx;
  logic [WW-1:0] word_idx;
  logic [HDR_LEN-1:0] total, hdr;
  assign hs = rx_valid && rx_ready;
  // header value as it will sit in [127:96] once this byte is shifted in
  assign hdr = {rx_data, prog_loaddata[4*INSN_LEN-1 -: 24]};
  assign last_line = HDR_LEN'(line_idx) + 1 == total;
  assign last_word = HDR_LEN'(word_idx) + 1 == total;
  prog_byte_asm u_asm (
    .clk       (clk),
    .reset     (reset),
    .clr       (state != nxt),
    .shift     (hs),
    .din       (rx_data),
    .data      (prog_loaddata),
    .line_done (line_done),
    .word_done (word_done)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state    <= HDR_I;
      wr       <= 1'b0;
      line_idx <= '0;
      word_idx <= '0;
      total    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      state <= nxt;
      wr    <= hs && ((state == IMEM && line_done) || (state == DMEM && word_done));
      if (hs && word_done && (state == HDR_I || state == HDR_D)) total <= hdr;
      if (wr && state == IMEM) line_idx <= line_idx + 10'd1;
      if (wr && state == DMEM) word_idx <= word_idx + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      if (hs) csum <= csum ^ rx_data;
`endif
    end
  always_comb begin
    nxt = state;
    case (state)
      HDR_I: if (hs && word_done)
        nxt = hdr > HDR_LEN'(IMEM_LINES) ? ERR : hdr == '0 ? HDR_D : IMEM;
      IMEM:  if (wr) nxt = last_line ? HDR_D : IMEM;
      HDR_D: if (hs && word_done)
        nxt = hdr > HDR_LEN'(DMEM_WORDS) ? ERR : hdr == '0 ? FIN : DMEM;
      DMEM:  if (wr && last_word) nxt = FIN;
`ifdef PROG_LOADER_CHECKSUM_EN
      CSUM:  if (hs) nxt = rx_data == csum ? DONE : ERR;
`endif
      default: nxt = state;
    endcase
  end
  always_comb begin
    rx_ready      = !wr && state inside {HDR_I, IMEM, HDR_D, DMEM, CSUM};
    prog_loading  = state != DONE;
    loaded        = state == DONE;
    load_err      = state == ERR;
    prog_imem_we  = wr && state == IMEM;
    prog_dmem_we  = wr && state == DMEM;
    prog_loadaddr = state == IMEM ? ADDR_LEN'(line_idx) << 4 :
                    state == DMEM ? ADDR_LEN'(word_idx) << 2 : '0;
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader
module tb_prog_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_ready, prog_loading, prog_imem_we, prog_dmem_we, loaded, load_err;
  logic [127:0] prog_loaddata;
  logic [31:0] prog_loadaddr;
  int n_cmp = 0;
  int n_bad = 0;
  int rdy_bad = 0;
  logic [31:0] ia[$], da[$];
  logic [127:0] id[$], dd[$];

  always #5 clk = ~clk;

  prog_loader dut (
    .clk           (clk),
    .reset         (reset),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .prog_loading  (prog_loading),
    .prog_loaddata (prog_loaddata),
    .prog_loadaddr (prog_loadaddr),
    .prog_imem_we  (prog_imem_we),
    .prog_dmem_we  (prog_dmem_we),
    .loaded        (loaded),
    .load_err      (load_err)
  );

  always @(negedge clk) begin
    if (prog_imem_we) begin
      ia.push_back(prog_loadaddr);
      id.push_back(prog_loaddata);
    end
    if (prog_dmem_we) begin
      da.push_back(prog_loadaddr);
      dd.push_back(prog_loaddata);
    end
    if ((prog_imem_we || prog_dmem_we) && rx_ready) rdy_bad++;
  end

  function automatic logic [127:0] make_line(input logic [7:0] base);
    logic [127:0] l;
    for (int i = 0; i < 16; i++) l[8*i +: 8] = base + 8'(i);
    return l;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // called at a negedge; returns at the negedge after the byte is consumed
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    rx_valid = 1'b1;
    rx_data = b;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_byte: rx_ready stayed 0, byte %h want accepted", b);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_line(input logic [7:0] base, input bit gap);
    for (int i = 0; i < 16; i++) begin
      send_byte(base + 8'(i));
      if (gap) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (prog_loading !== 1'b1) begin n_bad++; $display("FAIL reset_loading: got %b want 1", prog_loading); end
    n_cmp++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", rx_ready); end
    n_cmp++; if ({loaded, load_err, prog_imem_we, prog_dmem_we} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {loaded, load_err, prog_imem_we, prog_dmem_we}); end
    n_cmp++; if (prog_loadaddr !== 32'h0 || prog_loaddata !== 128'h0) begin n_bad++; $display("FAIL reset_addr_data: got %h/%h want 0/0", prog_loadaddr, prog_loaddata); end
  endtask

  task automatic test_imem();
    int ib, db;
    do_reset();
    ib = ia.size(); db = da.size();
    send_word(32'd2);
    send_line(8'h00, 1'b0);
    n_cmp++; if (prog_imem_we !== 1'b1 || rx_ready !== 1'b0) begin n_bad++; $display("FAIL imem_strobe: got we=%b rdy=%b want we=1 rdy=0", prog_imem_we, rx_ready); end
    send_line(8'h10, 1'b0);
    send_word(32'd0);
    n_cmp++; if (loaded !== 1'b1 || prog_loading !== 1'b0) begin n_bad++; $display("FAIL imem_done: got loaded=%b loading=%b want 1/0", loaded, prog_loading); end
    repeat (2) @(negedge clk);
    n_cmp++; if (ia.size() - ib !== 2 || da.size() !== db) begin n_bad++; $display("FAIL imem_count: got %0d/%0d want 2/0", ia.size() - ib, da.size() - db); end
    if (ia.size() - ib == 2) begin
      n_cmp++; if (ia[ib] !== 32'h0 || id[ib] !== make_line(8'h00)) begin n_bad++; $display("FAIL imem_line0: got %h/%h want 0/%h", ia[ib], id[ib], make_line(8'h00)); end
      n_cmp++; if (ia[ib+1] !== 32'h10 || id[ib+1] !== make_line(8'h10)) begin n_bad++; $display("FAIL imem_line1: got %h/%h want 10/%h", ia[ib+1], id[ib+1], make_line(8'h10)); end
    end
    rx_valid = 1'b1;
    rx_data = 8'h77;
    repeat (3) @(negedge clk);
    n_cmp++; if (rx_ready !== 1'b0 || loaded !== 1'b1 || ia.size() - ib !== 2) begin n_bad++; $display("FAIL done_ignores: got rdy=%b loaded=%b writes=%0d want 0/1/2", rx_ready, loaded, ia.size() - ib); end
    rx_valid = 1'b0;
  endtask

  task automatic test_dmem();
    int db;
    logic [31:0] w[3] = '{32'hDEADBEEF, 32'h1, 32'h2};
    do_reset();
    db = da.size();
    send_word(32'd0);
    send_word(32'd3);
    for (int i = 0; i < 3; i++) send_word(w[i]);
    n_cmp++; if (prog_dmem_we !== 1'b1 || rx_ready !== 1'b0 || loaded !== 1'b0) begin n_bad++; $display("FAIL dmem_last_strobe: got we=%b rdy=%b loaded=%b want 1/0/0", prog_dmem_we, rx_ready, loaded); end
    @(negedge clk);
    n_cmp++; if (loaded !== 1'b1 || prog_loading !== 1'b0) begin n_bad++; $display("FAIL dmem_done: got loaded=%b loading=%b want 1/0", loaded, prog_loading); end
    n_cmp++; if (da.size() - db !== 3) begin n_bad++; $display("FAIL dmem_count: got %0d want 3", da.size() - db); end
    if (da.size() - db == 3)
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (da[db+i] !== 32'(4*i) || dd[db+i][127:96] !== w[i]) begin n_bad++; $display("FAIL dmem_word%0d: got %h/%h want %h/%h", i, da[db+i], dd[db+i][127:96], 4*i, w[i]); end
      end
  endtask

  task automatic test_overflow();
    int ib, db;
    do_reset();
    ib = ia.size(); db = da.size();
    send_word(32'd513);
    n_cmp++; if (load_err !== 1'b1 || rx_ready !== 1'b0 || prog_loading !== 1'b1 || loaded !== 1'b0) begin n_bad++; $display("FAIL n_overflow: got err=%b rdy=%b loading=%b loaded=%b want 1/0/1/0", load_err, rx_ready, prog_loading, loaded); end
    rx_valid = 1'b1;
    rx_data = 8'h55;
    repeat (4) @(negedge clk);
    rx_valid = 1'b0;
    n_cmp++; if (load_err !== 1'b1 || rx_ready !== 1'b0 || ia.size() !== ib || da.size() !== db) begin n_bad++; $display("FAIL err_held: got err=%b rdy=%b writes=%0d want 1/0/0", load_err, rx_ready, ia.size() - ib + da.size() - db); end
    do_reset();
    send_word(32'd0);
    send_word(32'd4097);
    n_cmp++; if (load_err !== 1'b1 || prog_loading !== 1'b1) begin n_bad++; $display("FAIL m_overflow: got err=%b loading=%b want 1/1", load_err, prog_loading); end
  endtask

  task automatic test_back_to_back();
    int ib;
    do_reset();
    ib = ia.size();
    send_word(32'd1);
    send_line(8'h50, 1'b1);
    send_word(32'd0);
    repeat (2) @(negedge clk);
    n_cmp++; if (ia.size() - ib !== 1 || loaded !== 1'b1) begin n_bad++; $display("FAIL gap_count: got %0d/%b want 1/1", ia.size() - ib, loaded); end
    if (ia.size() - ib == 1) begin
      n_cmp++; if (ia[ib] !== 32'h0 || id[ib] !== make_line(8'h50)) begin n_bad++; $display("FAIL gap_line: got %h/%h want 0/%h", ia[ib], id[ib], make_line(8'h50)); end
    end
    n_cmp++; if (rdy_bad !== 0) begin n_bad++; $display("FAIL strobe_ready: got %0d want 0", rdy_bad); end
  endtask

  task automatic test_reset_mid();
    int ib, db;
    do_reset();
    send_word(32'd2);
    send_line(8'h00, 1'b0);
    for (int i = 0; i < 7; i++) send_byte(8'h10 + 8'(i));
    do_reset();
    n_cmp++; if (rx_ready !== 1'b1 || prog_loading !== 1'b1 || prog_loadaddr !== 32'h0) begin n_bad++; $display("FAIL mid_reset_state: got rdy=%b loading=%b addr=%h want 1/1/0", rx_ready, prog_loading, prog_loadaddr); end
    ib = ia.size(); db = da.size();
    send_word(32'd1);
    send_line(8'hA0, 1'b0);
    send_word(32'd1);
    send_word(32'h11223344);
    repeat (2) @(negedge clk);
    n_cmp++; if (loaded !== 1'b1 || ia.size() - ib !== 1 || da.size() - db !== 1) begin n_bad++; $display("FAIL mid_done: got loaded=%b i=%0d d=%0d want 1/1/1", loaded, ia.size() - ib, da.size() - db); end
    if (ia.size() - ib == 1 && da.size() - db == 1) begin
      n_cmp++; if (ia[ib] !== 32'h0 || id[ib] !== make_line(8'hA0)) begin n_bad++; $display("FAIL mid_imem: got %h/%h want 0/%h", ia[ib], id[ib], make_line(8'hA0)); end
      n_cmp++; if (da[db] !== 32'h0 || dd[db][127:96] !== 32'h11223344) begin n_bad++; $display("FAIL mid_dmem: got %h/%h want 0/11223344", da[db], dd[db][127:96]); end
    end
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  // stream XOR: 0x01 header, 0x30..0x3F cancel out, zeros -> 0x01
  task automatic test_checksum();
    do_reset();
    send_word(32'd1);
    send_line(8'h30, 1'b0);
    send_word(32'd0);
    n_cmp++; if (rx_ready !== 1'b1 || loaded !== 1'b0) begin n_bad++; $display("FAIL csum_wait: got rdy=%b loaded=%b want 1/0", rx_ready, loaded); end
    send_byte(8'hFF);
    n_cmp++; if (load_err !== 1'b1 || loaded !== 1'b0) begin n_bad++; $display("FAIL csum_bad: got err=%b loaded=%b want 1/0", load_err, loaded); end
    do_reset();
    send_word(32'd1);
    send_line(8'h30, 1'b0);
    send_word(32'd0);
    send_byte(8'h01);
    n_cmp++; if (loaded !== 1'b1 || load_err !== 1'b0) begin n_bad++; $display("FAIL csum_good: got loaded=%b err=%b want 1/0", loaded, load_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_imem();
    test_dmem();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
